// File: rtl/pll_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock,
// retries on timeout or lock loss, and applies DYNAMICDELAY updates while running.
module pll_sequencer #(
    parameter int unsigned RESET_CYCLES       = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned DELAY_SETTLE       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pll_lock,
    input  logic       delay_req,
    input  logic [7:0] delay_val,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic [7:0] pll_dynamicdelay,
    output logic       ready,
    output logic       delay_ack,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitLock = 3'd2,
        StStable   = 3'd3,
        StRun      = 3'd4,
        StDelayUpd = 3'd5,
        StFail     = 3'd6
    } state_e;

    // Terminal counts: the counter starts at 0 on entry, so the last cycle is N-1.
    localparam logic [15:0] ResetLast   = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] StableLast  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] SettleLast  = 16'(DELAY_SETTLE - 1);
    localparam logic [15:0] RetryMax    = 16'(MAX_RETRIES);

    logic [1:0]  sync_q;
    logic        lock;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] retries_q, retries_d;
    logic [7:0]  dyn_q, dyn_d;
    logic        ack_q, ack_d;
    logic        resetb_q, resetb_d;
    logic        bypass_q, bypass_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;
    logic [1:0]  retry_cnt_q, retry_cnt_d;
    logic        retry_path;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock = sync_q[1];

    // Next-state, counter, retry bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        retries_d  = retries_q;
        dyn_d      = dyn_q;
        ack_d      = 1'b0;
        retry_path = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StReset;
            end
            StReset: begin
                if (cnt_q == ResetLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock) state_d = StStable;
                else if (cnt_q == TimeoutLast) retry_path = 1'b1;
            end
            StStable: begin
                // A dropout here is not a retry; just go back to waiting for lock.
                if (!lock) state_d = StWaitLock;
                else if (cnt_q == StableLast) state_d = StRun;
            end
            StRun: begin
                // Lock loss takes priority over a simultaneous delay request.
                if (!lock) begin
                    retry_path = 1'b1;
                end else if (delay_req) begin
                    dyn_d   = delay_val;
                    state_d = StDelayUpd;
                end
            end
            StDelayUpd: begin
                if (!lock) begin
                    retry_path = 1'b1;
                end else if (cnt_q == SettleLast) begin
                    ack_d   = 1'b1;
                    state_d = StRun;
                end
            end
            StFail: begin
                if (start) begin
                    retries_d = 16'd0;
                    state_d   = StReset;
                end
            end
            default: state_d = StIdle;
        endcase

        if (retry_path) begin
            if (retries_q == RetryMax) begin
                state_d = StFail;
            end else begin
                retries_d = retries_q + 16'd1;
                state_d   = StReset;
            end
        end

        if (state_d == StRun) retries_d = 16'd0;
        if (state_d != state_q) cnt_d = 16'd0;

        resetb_d    = (state_d == StWaitLock) || (state_d == StStable) ||
                      (state_d == StRun) || (state_d == StDelayUpd);
        bypass_d    = (state_d == StFail);
        fail_d      = (state_d == StFail);
        ready_d     = (state_d == StRun);
        retry_cnt_d = (retries_d > 16'd3) ? 2'd3 : retries_d[1:0];
    end

    // FSM state, counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            retries_q   <= 16'd0;
            dyn_q       <= 8'd0;
            ack_q       <= 1'b0;
            resetb_q    <= 1'b0;
            bypass_q    <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            dyn_q       <= dyn_d;
            ack_q       <= ack_d;
            resetb_q    <= resetb_d;
            bypass_q    <= bypass_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign pll_resetb       = resetb_q;
    assign pll_bypass       = bypass_q;
    assign pll_dynamicdelay = dyn_q;
    assign ready            = ready_q;
    assign delay_ack        = ack_q;
    assign fail             = fail_q;
    assign retry_cnt        = retry_cnt_q;
    assign state            = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Bench for pll_sequencer: directed bring-up/glitch/timeout/delay/contention/reset
// scenarios followed by random stimulus, all checked against a countdown-based model.
module tb_pll_sequencer;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 20;
    localparam int MR = 2;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pll_lock;
    logic       delay_req;
    logic [7:0] delay_val;
    logic       pll_resetb;
    logic       pll_bypass;
    logic [7:0] pll_dynamicdelay;
    logic       ready;
    logic       delay_ack;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: state number from the spec, cycles remaining in it,
    // restarts since RUN, delay value, ack pulse and the lock pipeline.
    int         m_state;
    int         m_left;
    int         m_retry;
    logic [7:0] m_dyn;
    logic       m_ack;
    logic       m_l1, m_l2;

    pll_sequencer #(
        .RESET_CYCLES      (RC),
        .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT      (LT),
        .MAX_RETRIES       (MR),
        .DELAY_SETTLE      (DS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pll_lock        (pll_lock),
        .delay_req       (delay_req),
        .delay_val       (delay_val),
        .pll_resetb      (pll_resetb),
        .pll_bypass      (pll_bypass),
        .pll_dynamicdelay(pll_dynamicdelay),
        .ready           (ready),
        .delay_ack       (delay_ack),
        .fail            (fail),
        .retry_cnt       (retry_cnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_retry = 0;
        m_dyn   = 8'd0;
        m_ack   = 1'b0;
        m_l1    = 1'b0;
        m_l2    = 1'b0;
    endtask

    task automatic enter(input int s);
        m_state = s;
        case (s)
            1: m_left = RC;
            2: m_left = LT;
            3: m_left = LS;
            5: m_left = DS;
            default: m_left = 0;
        endcase
        if (s == 4) m_retry = 0;
    endtask

    task automatic take_retry();
        if (m_retry == MR) enter(6);
        else begin
            m_retry = m_retry + 1;
            enter(1);
        end
    endtask

    task automatic model_step();
        logic lk;
        if (rst) begin
            model_reset();
            return;
        end
        lk    = m_l2;
        m_l2  = m_l1;
        m_l1  = pll_lock;
        m_ack = 1'b0;
        case (m_state)
            0: if (start) enter(1);
            1: begin
                m_left--;
                if (m_left == 0) enter(2);
            end
            2: begin
                if (lk) enter(3);
                else begin
                    m_left--;
                    if (m_left == 0) take_retry();
                end
            end
            3: begin
                if (!lk) enter(2);
                else begin
                    m_left--;
                    if (m_left == 0) enter(4);
                end
            end
            4: begin
                if (!lk) take_retry();
                else if (delay_req) begin
                    m_dyn = delay_val;
                    enter(5);
                end
            end
            5: begin
                if (!lk) take_retry();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        enter(4);
                        m_ack = 1'b1;
                    end
                end
            end
            6: if (start) begin
                m_retry = 0;
                enter(1);
            end
            default: model_reset();
        endcase
    endtask

    task automatic compare_all();
        int rexp;
        rexp = (m_retry > 3) ? 3 : m_retry;
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("pll_resetb", 32'(pll_resetb),
                 32'(m_state == 2 || m_state == 3 || m_state == 4 || m_state == 5));
        check_eq("pll_bypass", 32'(pll_bypass), 32'(m_state == 6));
        check_eq("fail", 32'(fail), 32'(m_state == 6));
        check_eq("ready", 32'(ready), 32'(m_state == 4));
        check_eq("delay_ack", 32'(delay_ack), 32'(m_ack));
        check_eq("retry_cnt", 32'(retry_cnt), 32'(rexp));
        check_eq("dynamicdelay", 32'(pll_dynamicdelay), 32'(m_dyn));
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; leaves inputs idle and the lock pipeline filled.
    task automatic do_reset(input logic lock_val);
        rst       = 1'b1;
        start     = 1'b0;
        delay_req = 1'b0;
        delay_val = 8'd0;
        pll_lock  = lock_val;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic bring_up();
        do_reset(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !ready; i++) tick();
        check_eq("bringup_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        pll_lock  = 1'b0;
        delay_req = 1'b0;
        delay_val = 8'd0;
        model_reset();
        @(negedge clk);

        // Bring-up timeline, start sampled at cycle 0.
        do_reset(1'b1);
        check_eq("rst_state", 32'(state), 32'd0);
        start = 1'b1;
        tick();
        check_eq("bu_c1_reset", 32'(state), 32'd1);
        start = 1'b0;
        repeat (3) tick();
        check_eq("bu_c4_resetb", 32'(pll_resetb), 32'd0);
        tick();
        check_eq("bu_c5_wait", 32'(state), 32'd2);
        check_eq("bu_c5_resetb", 32'(pll_resetb), 32'd1);
        tick();
        check_eq("bu_c6_stable", 32'(state), 32'd3);
        repeat (7) tick();
        check_eq("bu_c13_notready", 32'(ready), 32'd0);
        tick();
        check_eq("bu_c14_ready", 32'(ready), 32'd1);

        // One-cycle lock glitch during STABLE.
        do_reset(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int i = 0; i < 20 && state != 3'd2; i++) tick();
        check_eq("glitch_wait", 32'(state), 32'd2);
        check_eq("glitch_retry", 32'(retry_cnt), 32'd0);
        n = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            tick();
            n++;
        end
        check_eq("glitch_ready_cycles", 32'(n), 32'd9);

        // Lock never arrives: three rounds then FAIL, start recovers.
        do_reset(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("to_r0", 32'(retry_cnt), 32'd0);
        repeat (RC + LT) tick();
        check_eq("to_r1_state", 32'(state), 32'd1);
        check_eq("to_r1", 32'(retry_cnt), 32'd1);
        repeat (RC + LT) tick();
        check_eq("to_r2", 32'(retry_cnt), 32'd2);
        repeat (RC + LT) tick();
        check_eq("to_fail_state", 32'(state), 32'd6);
        check_eq("to_fail", 32'(fail), 32'd1);
        check_eq("to_bypass", 32'(pll_bypass), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("to_clear_state", 32'(state), 32'd1);
        check_eq("to_clear_fail", 32'(fail), 32'd0);

        // Delay update in RUN.
        bring_up();
        delay_req = 1'b1;
        delay_val = 8'hA5;
        tick();
        delay_req = 1'b0;
        check_eq("dly_val", 32'(pll_dynamicdelay), 32'hA5);
        check_eq("dly_ready0", 32'(ready), 32'd0);
        repeat (2) tick();
        check_eq("dly_ready0_c3", 32'(ready), 32'd0);
        check_eq("dly_noack", 32'(delay_ack), 32'd0);
        tick();
        check_eq("dly_ack", 32'(delay_ack), 32'd1);
        check_eq("dly_ready1", 32'(ready), 32'd1);
        tick();
        check_eq("dly_ack_pulse", 32'(delay_ack), 32'd0);

        // Lock loss in the same cycle as a delay request.
        pll_lock = 1'b0;
        repeat (2) tick();
        delay_req = 1'b1;
        delay_val = 8'h3C;
        tick();
        delay_req = 1'b0;
        check_eq("cont_state", 32'(state), 32'd1);
        check_eq("cont_retry", 32'(retry_cnt), 32'd1);
        check_eq("cont_dyn", 32'(pll_dynamicdelay), 32'hA5);
        check_eq("cont_noack", 32'(delay_ack), 32'd0);

        // Asynchronous reset in the middle of a delay update.
        bring_up();
        delay_req = 1'b1;
        delay_val = 8'h5A;
        tick();
        delay_req = 1'b0;
        check_eq("mid_in_dly", 32'(state), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_state", 32'(state), 32'd0);
        check_eq("mid_resetb", 32'(pll_resetb), 32'd0);
        check_eq("mid_ready", 32'(ready), 32'd0);
        check_eq("mid_ack", 32'(delay_ack), 32'd0);
        check_eq("mid_dyn", 32'(pll_dynamicdelay), 32'd0);
        check_eq("mid_bypass", 32'(pll_bypass), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;

        // Random stimulus against the model.
        pll_lock = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
            start     = ($urandom_range(0, 15) == 0);
            delay_req = ($urandom_range(0, 4) == 0);
            delay_val = 8'($urandom);
            rst       = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 The module SHALL have these parameters: RESET_CYCLES, default 16, cycles the PLL is held in reset; LOCK_STABLE_CYCLES, default 256, consecutive locked cycles required before ready; LOCK_TIMEOUT, default 65535, cycles allowed in WAIT_LOCK; MAX_RETRIES, default 3, PLL restarts allowed before FAIL; DELAY_SETTLE, default 16, cycles to wait after a DYNAMICDELAY change. Every parameter SHALL be between 1 and 65535.
REQ-002 The module SHALL have these ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
start  in  1  level; starts the sequence from IDLE, or clears FAIL
pll_lock  in  1  PLL LOCK output, asynchronous to clk
delay_req  in  1  request to apply delay_val
delay_val  in  8  new DYNAMICDELAY value
pll_resetb  out  1  to PLL RESETB, active-low
pll_bypass  out  1  to PLL BYPASS
pll_dynamicdelay  out  8  to PLL DYNAMICDELAY
ready  out  1  PLL locked and stable
delay_ack  out  1  one-cycle pulse when a delay update completes
fail  out  1  retries exhausted
retry_cnt  out  2  restarts since the last RUN
state  out  3  current state encoding, for debug
REQ-003 The clock SHALL be a single clock, and the reset SHALL be asynchronous and active-high; all registers SHALL be clocked by the rising edge of clk.

Function
REQ-004 pll_lock SHALL pass through a 2-flop synchronizer; "lock" below means the synchronized value, which lags pll_lock by 2 cycles.
REQ-005 States SHALL be IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, DELAY_UPD=5, FAIL=6; all outputs SHALL be registered.
REQ-006 IDLE: if start=1, go to RESET and clear the counter; otherwise stay in IDLE.
REQ-007 RESET: pll_resetb=0 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK with pll_resetb=1.
REQ-008 WAIT_LOCK: if lock=1, go to STABLE; if LOCK_TIMEOUT cycles elapse without lock, take the retry path (REQ-012).
REQ-009 STABLE: after LOCK_STABLE_CYCLES consecutive cycles with lock=1, go to RUN; if lock=0, go back to WAIT_LOCK, restart the counter, and do not increment retry_cnt.
REQ-010 RUN: ready=1 and retry_cnt is cleared to 0. If lock=0, go to the retry path; otherwise, if delay_req=1, latch delay_val into pll_dynamicdelay and go to DELAY_UPD with ready=0.
REQ-011 DELAY_UPD: after DELAY_SETTLE cycles, pulse delay_ack for one cycle and return to RUN with ready=1; if lock=0 at any point, abort without delay_ack and take the retry path.
REQ-012 Retry path: if retry_cnt == MAX_RETRIES, go to FAIL; otherwise increment retry_cnt and go to RESET. retry_cnt SHALL saturate at 3.
REQ-013 FAIL: fail=1, pll_bypass=1, pll_resetb=0. If start=1, go to RESET with fail=0, pll_bypass=0 and retry_cnt=0.
REQ-014 start SHALL be ignored in every state except IDLE and FAIL; delay_req SHALL be ignored in every state except RUN.
REQ-015 When lock=0 and delay_req=1 in the same RUN cycle, lock loss SHALL win: pll_dynamicdelay is unchanged and no delay_ack is issued.
REQ-016 One 16-bit counter SHALL serve all states; it clears on every state transition and does not wrap.
REQ-017 pll_dynamicdelay SHALL hold its value across retries and FAIL, and change only in RUN on delay_req.

Reset
REQ-018 While rst=1, the block SHALL be in IDLE with pll_resetb=0, pll_bypass=0, pll_dynamicdelay=0, ready=0, delay_ack=0, fail=0, retry_cnt=0, counter=0, and synchronizer=0.
REQ-019 Asserting rst in any state, including mid-DELAY_UPD, SHALL force the REQ-018 values immediately (asynchronously), with no delay_ack issued.

Verification
Bench parameters: RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=20, MAX_RETRIES=2, DELAY_SETTLE=3.
REQ-020 Bring-up: pll_lock=1 held, start sampled at cycle 0 -> pll_resetb=0 in cycles 1-4, WAIT_LOCK at cycle 5, STABLE in cycles 6-13, ready=1 from cycle 14.
REQ-021 Lock glitch: pll_lock drops for 1 cycle during STABLE -> WAIT_LOCK re-entered, retry_cnt stays 0, and ready rises no earlier than 8 full locked cycles later.
REQ-022 Timeout/FAIL: pll_lock held 0 -> 3 RESET/WAIT_LOCK rounds with retry_cnt 0, 1, 2 -> FAIL with fail=1, pll_bypass=1; start then clears FAIL and enters RESET.
REQ-023 Delay update: in RUN, delay_req with delay_val=0xA5 -> pll_dynamicdelay=0xA5 next cycle, ready=0 for 3 cycles, one delay_ack pulse, then ready=1.
REQ-024 Contention: lock loss in the same cycle as delay_req with delay_val=0x3C -> no delay_ack, pll_dynamicdelay unchanged, RESET entered with retry_cnt=1.
REQ-025 Mid-operation reset: rst asserted during DELAY_UPD -> all outputs at REQ-018 values in the same cycle, and state=IDLE.
